// File: rtl/conv_column_sequencer_if.sv
// Handshake and control bundle between the column sequencer and its
// neighbours: the column source, the convolution engine and the result sink.
//
// Handshake semantics (both directions): a transfer happens on a rising
// clock edge where the producer's valid and the consumer's ready are both
// high. A producer holds valid and its payload stable until that edge.
// The ready output never depends on the matching valid input.
interface conv_column_sequencer_if #(
   parameter int IDX_W = 10
);
   logic             i_start;
   logic             i_col_valid;
   logic             o_col_ready;
   logic             o_load_en;
   logic             o_pad_en;
   logic [1:0]       o_load_sel;
   logic             o_conv_start;
   logic [1:0]       o_conv_base;
   logic             i_conv_done;
   logic             o_out_valid;
   logic             i_out_ready;
   logic [IDX_W-1:0] o_out_idx;
   logic             o_busy;
   logic             o_frame_done;

   // Sequencer side.
   modport master (
      input  i_start, i_col_valid, i_conv_done, i_out_ready,
      output o_col_ready, o_load_en, o_pad_en, o_load_sel, o_conv_start,
             o_conv_base, o_out_valid, o_out_idx, o_busy, o_frame_done
   );

   // Environment side: column source, engine and result sink.
   modport slave (
      output i_start, i_col_valid, i_conv_done, i_out_ready,
      input  o_col_ready, o_load_en, o_pad_en, o_load_sel, o_conv_start,
             o_conv_base, o_out_valid, o_out_idx, o_busy, o_frame_done
   );
endinterface

// File: rtl/conv_column_sequencer.sv
// Frame-level controller for the column-based 3x3 convolution engine.
// Streams IMG_WIDTH columns through a 4-slot rotating column buffer, adds a
// zero column at each image edge, fires one convolution per output column
// and hands every result downstream over a valid/ready handshake.
// The window for output k starts at slot k mod 4; the slot being written is
// always the one just past the live three-slot window.
module conv_column_sequencer #(
   parameter int IMG_WIDTH = 640,
   parameter int IDX_W     = 10
) (
   input  logic                     clock,
   input  logic                     i_reset,
   conv_column_sequencer_if.master  bus,
   output logic [3:0]               state_dbg
);

   typedef enum logic [3:0] {
      IDLE, PAD_L, FILL, CONV, WAIT_DONE, OUT, FETCH, PAD_R, DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(IMG_WIDTH - 1);
   localparam logic [IDX_W-1:0] WIDTH_CNT = IDX_W'(IMG_WIDTH);
   localparam logic [IDX_W-1:0] ONE_CNT   = IDX_W'(1);

   state_t           state;
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic [IDX_W-1:0] col_cnt;
   logic [IDX_W-1:0] out_idx;

   logic col_phase;
   logic pad_phase;

   assign col_phase = (state == FILL) || (state == FETCH);
   assign pad_phase = (state == PAD_L) || (state == PAD_R);

   // Frame sequencing: state, buffer pointers and column counters.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         state   <= IDLE;
         wr_ptr  <= 2'd0;
         rd_ptr  <= 2'd0;
         col_cnt <= '0;
         out_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  wr_ptr  <= 2'd0;
                  rd_ptr  <= 2'd0;
                  col_cnt <= '0;
                  out_idx <= '0;
                  state   <= PAD_L;
               end
            end
            PAD_L: begin
               wr_ptr <= wr_ptr + 2'd1;
               state  <= FILL;
            end
            FILL: begin
               if (bus.i_col_valid) begin
                  wr_ptr  <= wr_ptr + 2'd1;
                  col_cnt <= col_cnt + ONE_CNT;
                  // Window 0 needs the left pad plus real columns 0 and 1.
                  if (col_cnt == ONE_CNT) state <= CONV;
               end
            end
            CONV: begin
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (bus.i_conv_done) state <= OUT;
            end
            OUT: begin
               if (bus.i_out_ready) begin
                  rd_ptr <= rd_ptr + 2'd1;
                  if (out_idx == LAST_IDX) begin
                     state <= DONE;
                  end else begin
                     out_idx <= out_idx + ONE_CNT;
                     // Real columns left: fetch one; otherwise the right pad.
                     state   <= (col_cnt < WIDTH_CNT) ? FETCH : PAD_R;
                  end
               end
            end
            FETCH: begin
               if (bus.i_col_valid) begin
                  wr_ptr  <= wr_ptr + 2'd1;
                  col_cnt <= col_cnt + ONE_CNT;
                  state   <= CONV;
               end
            end
            PAD_R: begin
               wr_ptr <= wr_ptr + 2'd1;
               state  <= CONV;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Output decode from registered state; only load_en in column phases
   // also follows the upstream valid.
   assign bus.o_col_ready  = col_phase;
   assign bus.o_load_en    = pad_phase || (col_phase && bus.i_col_valid);
   assign bus.o_pad_en     = pad_phase;
   assign bus.o_load_sel   = (pad_phase || col_phase) ? wr_ptr : 2'd0;
   assign bus.o_conv_start = (state == CONV);
   assign bus.o_conv_base  = (state == CONV) ? rd_ptr : 2'd0;
   assign bus.o_out_valid  = (state == OUT);
   assign bus.o_out_idx    = (state == OUT) ? out_idx : '0;
   assign bus.o_busy       = (state != IDLE);
   assign bus.o_frame_done = (state == DONE);
   assign state_dbg        = state;

endmodule

// File: tb/tb_conv_column_sequencer.sv
// Bench for conv_column_sequencer: a 4-column instance for directed
// scenarios and a 640-column instance for back-to-back frames with stalls.
// A per-cycle monitor checks every load, strobe and result against the
// column arithmetic of the frame (load n -> slot n mod 4, pads first and
// last; strobe k -> base k mod 4 after k+3 loads; result k -> index k).
module tb_conv_column_sequencer;

   localparam int W_S = 4;
   localparam int W_L = 640;

   logic       clock = 1'b0;
   logic       rst_s;
   logic       rst_l;
   logic [3:0] state_dbg_s;
   logic [3:0] state_dbg_l;

   int n_vec = 0;
   int n_err = 0;

   // Monitor state, indexed by instance (0 = small, 1 = large).
   int         n_load [2];
   int         n_conv [2];
   int         n_out  [2];
   int         frames [2];
   bit         pv     [2];
   bit         prev_rst [2];
   logic [9:0] pidx   [2];

   // Transaction logs of the small instance.
   logic [2:0] log_ld [$];
   logic [1:0] log_cb [$];
   logic [9:0] log_oi [$];

   conv_column_sequencer_if #(.IDX_W(10)) bus_s ();
   conv_column_sequencer_if #(.IDX_W(10)) bus_l ();

   conv_column_sequencer #(.IMG_WIDTH(W_S), .IDX_W(10)) dut_s (
      .clock     (clock),
      .i_reset   (rst_s),
      .bus       (bus_s),
      .state_dbg (state_dbg_s)
   );

   conv_column_sequencer #(.IMG_WIDTH(W_L), .IDX_W(10)) dut_l (
      .clock     (clock),
      .i_reset   (rst_l),
      .bus       (bus_l),
      .state_dbg (state_dbg_l)
   );

   // Clock generation.
   always #5 clock = ~clock;

   // Watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time expired, required frames to finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_model(input int id);
      n_load[id] = 0;
      n_conv[id] = 0;
      n_out[id]  = 0;
      pv[id]     = 1'b0;
   endtask

   // Per-cycle check of one instance against the frame model.
   task automatic mon(input int id, input int w, input logic rst,
                      input logic col_valid, input logic out_ready,
                      input logic col_ready, input logic load_en, input logic pad_en,
                      input logic [1:0] load_sel, input logic conv_start,
                      input logic [1:0] conv_base, input logic out_valid,
                      input logic [9:0] out_idx, input logic busy, input logic frame_done);
      if (prev_rst[id])
         chk("rst_all_zero", {busy, col_ready, load_en, pad_en, conv_start, out_valid,
                              frame_done, load_sel, conv_base, out_idx}, 0);
      prev_rst[id] = rst;
      if (rst) begin
         clear_model(id);
         return;
      end
      if (load_en === 1'b1) begin
         chk("load_sel", load_sel, n_load[id] % 4);
         chk("load_pad", pad_en, (n_load[id] == 0) || (n_load[id] == w + 1));
         chk("load_budget", n_load[id] < w + 2, 1);
         if (pad_en !== 1'b1) chk("load_handshake", col_valid & col_ready, 1);
         if (id == 0) log_ld.push_back({pad_en, load_sel});
         n_load[id]++;
      end else begin
         chk("pad_without_load", pad_en, 0);
         if (col_ready === 1'b1) chk("valid_not_consumed", col_valid, 0);
      end
      if (conv_start === 1'b1) begin
         chk("conv_with_load", load_en, 0);
         chk("conv_base", conv_base, n_conv[id] % 4);
         chk("conv_window_loaded", n_load[id], n_conv[id] + 3);
         if (id == 0) log_cb.push_back(conv_base);
         n_conv[id]++;
      end
      if (pv[id]) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_idx", out_idx, pidx[id]);
      end
      if (out_valid === 1'b1) begin
         chk("out_idx", out_idx, n_out[id]);
         chk("out_after_conv", n_conv[id], n_out[id] + 1);
         if (out_ready === 1'b1) begin
            if (id == 0) log_oi.push_back(out_idx);
            n_out[id]++;
            pv[id] = 1'b0;
         end else begin
            pv[id]   = 1'b1;
            pidx[id] = out_idx;
         end
      end else begin
         pv[id] = 1'b0;
      end
      if (load_en || conv_start || out_valid) chk("busy_when_active", busy, 1);
      if (frame_done === 1'b1) begin
         chk("done_outs", n_out[id], w);
         chk("done_loads", n_load[id], w + 2);
         chk("done_convs", n_conv[id], w);
         chk("done_busy", busy, 1);
         clear_model(id);
         frames[id]++;
      end
   endtask

   // Compare process: both instances, every cycle, away from the active edge.
   always @(negedge clock) begin
      mon(0, W_S, rst_s, bus_s.i_col_valid, bus_s.i_out_ready, bus_s.o_col_ready,
          bus_s.o_load_en, bus_s.o_pad_en, bus_s.o_load_sel, bus_s.o_conv_start,
          bus_s.o_conv_base, bus_s.o_out_valid, bus_s.o_out_idx, bus_s.o_busy,
          bus_s.o_frame_done);
      mon(1, W_L, rst_l, bus_l.i_col_valid, bus_l.i_out_ready, bus_l.o_col_ready,
          bus_l.o_load_en, bus_l.o_pad_en, bus_l.o_load_sel, bus_l.o_conv_start,
          bus_l.o_conv_base, bus_l.o_out_valid, bus_l.o_out_idx, bus_l.o_busy,
          bus_l.o_frame_done);
   end

   // Hand-computed transaction logs of a 4-column frame.
   task automatic check_logs_w4();
      logic [2:0] exp_ld [6];
      exp_ld = '{3'b100, 3'b001, 3'b010, 3'b011, 3'b000, 3'b101};
      chk("log_load_count", log_ld.size(), 6);
      chk("log_conv_count", log_cb.size(), 4);
      chk("log_out_count", log_oi.size(), 4);
      for (int i = 0; i < 6; i++)
         if (i < log_ld.size()) chk($sformatf("log_load_%0d", i), log_ld[i], exp_ld[i]);
      for (int i = 0; i < 4; i++) begin
         if (i < log_cb.size()) chk($sformatf("log_conv_base_%0d", i), log_cb[i], i);
         if (i < log_oi.size()) chk($sformatf("log_out_idx_%0d", i), log_oi[i], i);
      end
   endtask

   // One frame on the small instance.
   // mode 0: immediate handshakes, i_start held during the frame
   // mode 1: i_out_ready low for 5 cycles at out_idx 1
   // mode 2: i_col_valid low for 3 cycles in the first FETCH
   // mode 3: reset while waiting for the engine
   task automatic frame_s(input int mode);
      int n, hold, stall, first_v, guard;
      bit out_seen, after_hold, after_stall, saw_conv, done_seen, stalling, check_slot;
      logic rdy, vld;
      n = 0; hold = 0; stall = 0; first_v = -1; guard = 0;
      out_seen = 0; after_hold = 0; after_stall = 0; saw_conv = 0; done_seen = 0;
      while (bus_s.o_busy && guard < 10) begin
         tick();
         guard++;
      end
      bus_s.i_start     = 1'b1;
      bus_s.i_col_valid = 1'b1;
      bus_s.i_out_ready = 1'b1;
      bus_s.i_conv_done = (mode != 3);
      while (!done_seen && n < 200) begin
         tick();
         n++;
         if (mode == 3 && saw_conv) begin
            rst_s = 1'b1;
            tick();
            chk("midframe_reset_outputs",
                {bus_s.o_busy, bus_s.o_col_ready, bus_s.o_load_en, bus_s.o_pad_en,
                 bus_s.o_conv_start, bus_s.o_out_valid, bus_s.o_frame_done,
                 bus_s.o_load_sel, bus_s.o_conv_base, bus_s.o_out_idx}, 0);
            rst_s = 1'b0;
            bus_s.i_conv_done = 1'b0;
            done_seen = 1;
         end else begin
            stalling = 0;
            check_slot = 0;
            if (after_hold) begin
               chk("bp_proceeds", {bus_s.o_out_valid, bus_s.o_col_ready}, 2'b01);
               after_hold = 0;
            end
            if (after_stall) begin
               chk("stall_then_conv", {bus_s.o_conv_start, bus_s.o_conv_base}, {1'b1, 2'd1});
               after_stall = 0;
            end
            if (bus_s.o_conv_start) saw_conv = 1;
            if (bus_s.o_out_valid && first_v < 0) first_v = n;
            rdy = 1'b1;
            vld = 1'b1;
            if (mode == 1 && bus_s.o_out_valid && bus_s.o_out_idx == 10'd1) begin
               if (hold < 5) begin
                  rdy = 1'b0;
                  chk("bp_valid", bus_s.o_out_valid, 1);
                  chk("bp_idx", bus_s.o_out_idx, 1);
                  chk("bp_no_col_ready", bus_s.o_col_ready, 0);
                  chk("bp_no_conv", bus_s.o_conv_start, 0);
                  hold++;
               end else if (hold == 5) begin
                  hold = 6;
                  after_hold = 1;
               end
            end
            if (mode == 2 && bus_s.o_col_ready && out_seen) begin
               if (stall < 3) begin
                  vld = 1'b0;
                  stall++;
                  stalling = 1;
               end else if (stall == 3) begin
                  stall = 4;
                  check_slot = 1;
                  after_stall = 1;
               end
            end
            bus_s.i_start     = (mode == 0) && bus_s.o_busy && !bus_s.o_frame_done;
            bus_s.i_out_ready = rdy;
            bus_s.i_col_valid = vld;
            #1;
            if (n == 1)
               chk("pad_left_slot0", {bus_s.o_load_en, bus_s.o_pad_en, bus_s.o_load_sel}, 4'b1100);
            if (stalling) begin
               chk("stall_no_load", bus_s.o_load_en, 0);
               chk("stall_no_conv", bus_s.o_conv_start, 0);
            end
            if (check_slot)
               chk("stall_col_slot", {bus_s.o_load_en, bus_s.o_pad_en, bus_s.o_load_sel}, 4'b1011);
            if (bus_s.o_out_valid && rdy) out_seen = 1;
            if (bus_s.o_frame_done) done_seen = 1;
         end
      end
      if (!done_seen) chk("frame_timeout", 0, 1);
      if (mode == 0) chk("first_valid_cycle", first_v, 6);
      if (mode == 1) chk("bp_hold_cycles", hold, 6);
      if (mode == 2) chk("stall_cycles", stall, 4);
      bus_s.i_start     = 1'b0;
      bus_s.i_col_valid = 1'b0;
      bus_s.i_conv_done = 1'b0;
   endtask

   // Two back-to-back full-size frames with random upstream/engine/downstream stalls.
   task automatic frames_l();
      int n, fd;
      n = 0; fd = 0;
      bus_l.i_start = 1'b1;
      while (fd < 2 && n < 20000) begin
         tick();
         n++;
         if (bus_l.o_frame_done) fd++;
         bus_l.i_start     = (fd < 2);
         bus_l.i_col_valid = ($urandom_range(0, 3) != 0);
         bus_l.i_out_ready = ($urandom_range(0, 3) != 0);
         bus_l.i_conv_done = ($urandom_range(0, 3) != 0);
      end
      if (fd < 2) chk("large_timeout", fd, 2);
      bus_l.i_start     = 1'b0;
      bus_l.i_col_valid = 1'b0;
      bus_l.i_out_ready = 1'b0;
      bus_l.i_conv_done = 1'b0;
   endtask

   // Directed sequence.
   initial begin
      rst_s = 1'b1;
      rst_l = 1'b1;
      bus_s.i_start = 1'b0; bus_s.i_col_valid = 1'b0;
      bus_s.i_conv_done = 1'b0; bus_s.i_out_ready = 1'b0;
      bus_l.i_start = 1'b0; bus_l.i_col_valid = 1'b0;
      bus_l.i_conv_done = 1'b0; bus_l.i_out_ready = 1'b0;
      repeat (3) tick();
      chk("reset_busy", bus_s.o_busy, 0);
      chk("reset_outputs",
          {bus_s.o_col_ready, bus_s.o_load_en, bus_s.o_conv_start, bus_s.o_out_valid,
           bus_s.o_frame_done, bus_l.o_busy, bus_l.o_col_ready}, 0);
      rst_s = 1'b0;
      rst_l = 1'b0;
      tick();

      // Spurious inputs in IDLE: no start, no loads, nothing consumed.
      bus_s.i_col_valid = 1'b1;
      bus_s.i_conv_done = 1'b1;
      bus_s.i_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_spurious", {bus_s.o_busy, bus_s.o_col_ready, bus_s.o_load_en}, 0);
      end
      bus_s.i_col_valid = 1'b0;
      bus_s.i_conv_done = 1'b0;

      log_ld.delete(); log_cb.delete(); log_oi.delete();
      frame_s(0);
      check_logs_w4();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("done_once", {bus_s.o_frame_done, bus_s.o_busy}, 0);
      end

      frame_s(1);
      frame_s(2);
      frame_s(3);
      log_ld.delete(); log_cb.delete(); log_oi.delete();
      frame_s(0);
      check_logs_w4();

      frames_l();
      repeat (3) tick();
      chk("small_frames_done", frames[0], 4);
      chk("large_frames_done", frames[1], 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
